// File: rtl/alu_loader_pkg.sv
// Shared types and word geometry for the program-RAM loader, RAM and ROM/ALU read path.
package alu_loader_pkg;
   localparam int ADDR_W = 8;
   localparam int OPND_W = 8;
   localparam int OP_W   = 4;
   localparam int WORD_W = 2*OPND_W + OP_W;

   typedef enum logic [2:0] {
      S_ADDR = 3'd0,
      S_A    = 3'd1,
      S_B    = 3'd2,
      S_OP   = 3'd3,
      S_WR   = 3'd4
   } ld_state_t;
endpackage

// File: rtl/btn_rise.sv
// Rising-edge detector for a debounced level button; history resets high so a
// button held through reset never produces an edge.
module btn_rise (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);
   logic btn_q;

   always_ff @(posedge clk) begin
      if (rst) btn_q <= 1'b1;
      else     btn_q <= btn;
   end

   assign rise = btn & ~btn_q;
endmodule

// File: rtl/alu_word_loader.sv
// Switch-driven loader: collects address, A, B and opcode one enter press at a
// time, then issues a single registered write of {A,B,OP} into program RAM.
module alu_word_loader
   import alu_loader_pkg::*;
#(
   parameter int ADDR_W = alu_loader_pkg::ADDR_W,
   parameter int OPND_W = alu_loader_pkg::OPND_W,
   parameter int OP_W   = alu_loader_pkg::OP_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 sw,
   input  logic                       enter,
   input  logic                       abort,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [2*OPND_W+OP_W-1:0]   wr_data,
   output logic [2:0]                 field,
   output logic [ADDR_W-1:0]          cur_addr,
   output logic [OP_W-1:0]            LEDs
);
   ld_state_t                  state_q;
   logic                       enter_rise;
   logic                       wr_en_q;
   logic [ADDR_W-1:0]          wr_addr_q;
   logic [2*OPND_W+OP_W-1:0]   wr_data_q;
   logic [ADDR_W-1:0]          cur_q;
   logic [OP_W-1:0]            leds_q;
   logic [OPND_W-1:0]          a_q;
   logic [OPND_W-1:0]          b_q;
   logic [OP_W-1:0]            op_q;

   btn_rise u_enter (
      .clk  (clk),
      .rst  (rst),
      .btn  (enter),
      .rise (enter_rise)
   );

   // The write port is loaded on the OP-capture edge, so wr_en is high exactly
   // while the FSM sits in S_WR and the port holds its contents afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_ADDR;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cur_q     <= '0;
         leds_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            S_ADDR: begin
               if (enter_rise) begin
                  cur_q   <= ADDR_W'(sw);
                  state_q <= S_A;
               end
            end
            S_A: begin
               if (abort) state_q <= S_ADDR;
               else if (enter_rise) begin
                  a_q     <= OPND_W'(sw);
                  state_q <= S_B;
               end
            end
            S_B: begin
               if (abort) state_q <= S_ADDR;
               else if (enter_rise) begin
                  b_q     <= OPND_W'(sw);
                  state_q <= S_OP;
               end
            end
            S_OP: begin
               if (abort) state_q <= S_ADDR;
               else if (enter_rise) begin
                  op_q      <= sw[OP_W-1:0];
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cur_q;
                  wr_data_q <= {a_q, b_q, sw[OP_W-1:0]};
                  leds_q    <= sw[OP_W-1:0];
                  state_q   <= S_WR;
               end
            end
            S_WR: begin
               cur_q   <= cur_q + 1'b1;
               state_q <= S_A;
            end
            default: state_q <= S_ADDR;
         endcase
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign field    = state_q;
   assign cur_addr = cur_q;
   assign LEDs     = leds_q;
endmodule

// File: tb/tb_alu_word_loader.sv
// Directed bench for alu_word_loader: field entry, packing, address wrap, abort and reset.
module tb_alu_word_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sw;
   logic        enter;
   logic        abort;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [19:0] wr_data;
   logic [2:0]  field;
   logic [7:0]  cur_addr;
   logic [3:0]  LEDs;

   int n_cmp  = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int base;

   alu_word_loader dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .enter    (enter),
      .abort    (abort),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .field    (field),
      .cur_addr (cur_addr),
      .LEDs     (LEDs)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [7:0] v);
      sw = v; enter = 1'b1; tick();
      enter = 1'b0; tick();
   endtask

   initial begin
      rst = 1'b1; sw = 8'h00; enter = 1'b1; abort = 1'b0;
      repeat (3) tick();
      // 1: enter held through reset release gives no edge
      rst = 1'b0;
      repeat (4) tick();
      enter = 1'b0;
      repeat (2) tick();
      chk("rst_field", 32'(field), 32'd0);
      chk("rst_cur", 32'(cur_addr), 32'h00);
      chk("rst_wrcnt", 32'(wr_cnt), 32'd0);
      chk("rst_leds", 32'(LEDs), 32'h0);
      chk("rst_wrdata", 32'(wr_data), 32'h0);

      // 2: basic word
      base = wr_cnt;
      press(8'h10); press(8'h25); press(8'h03);
      sw = 8'h0A; enter = 1'b1; tick();
      chk("t2_wren", 32'(wr_en), 32'd1);
      enter = 1'b0; tick();
      chk("t2_wren_off", 32'(wr_en), 32'd0);
      chk("t2_pulses", 32'(wr_cnt - base), 32'd1);
      chk("t2_addr", 32'(wr_addr), 32'h10);
      chk("t2_data", 32'(wr_data), 32'h2503A);
      chk("t2_leds", 32'(LEDs), 32'hA);
      chk("t2_field", 32'(field), 32'd1);
      chk("t2_cur", 32'(cur_addr), 32'h11);

      // 3: next word at auto-incremented address; abort during S_WR is ignored
      base = wr_cnt;
      press(8'h7F); press(8'h01);
      sw = 8'hF6; enter = 1'b1; tick();
      chk("t3_wren", 32'(wr_en), 32'd1);
      enter = 1'b0; abort = 1'b1; tick();
      chk("t3_addr", 32'(wr_addr), 32'h11);
      chk("t3_data", 32'(wr_data), 32'h7F016);
      chk("t3_field_after_wr", 32'(field), 32'd1);
      chk("t3_cur", 32'(cur_addr), 32'h12);
      tick();
      chk("t3_abort_field", 32'(field), 32'd0);
      chk("t3_pulses", 32'(wr_cnt - base), 32'd1);
      abort = 1'b0;

      // 4: address 0xFF wraps
      base = wr_cnt;
      press(8'hFF); press(8'h12); press(8'h34); press(8'h05);
      chk("t4_addr", 32'(wr_addr), 32'hFF);
      chk("t4_data", 32'(wr_data), 32'h12345);
      chk("t4_cur", 32'(cur_addr), 32'h00);
      chk("t4_field", 32'(field), 32'd1);
      chk("t4_pulses", 32'(wr_cnt - base), 32'd1);

      // 5: abort beats a simultaneous enter edge
      base = wr_cnt;
      press(8'h44);
      chk("t5_field_b", 32'(field), 32'd2);
      sw = 8'h99; enter = 1'b1; abort = 1'b1; tick();
      enter = 1'b0; abort = 1'b0; tick();
      chk("t5_field", 32'(field), 32'd0);
      chk("t5_a", 32'(dut.a_q), 32'h44);
      chk("t5_b_kept", 32'(dut.b_q), 32'h34);
      chk("t5_cur", 32'(cur_addr), 32'h00);
      chk("t5_pulses", 32'(wr_cnt - base), 32'd0);

      // 6: held enter advances once; reset during S_WR kills everything
      press(8'h30);
      sw = 8'h66; enter = 1'b1;
      repeat (20) tick();
      chk("t6_hold_field", 32'(field), 32'd2);
      enter = 1'b0; tick();
      press(8'h77);
      sw = 8'h0C; enter = 1'b1; tick();
      chk("t6_wren", 32'(wr_en), 32'd1);
      chk("t6_addr", 32'(wr_addr), 32'h30);
      chk("t6_data", 32'(wr_data), 32'h6677C);
      rst = 1'b1; enter = 1'b0; tick();
      chk("t6_rst_wren", 32'(wr_en), 32'd0);
      chk("t6_rst_field", 32'(field), 32'd0);
      chk("t6_rst_cur", 32'(cur_addr), 32'h00);
      chk("t6_rst_addr", 32'(wr_addr), 32'h00);
      rst = 1'b0; tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
